// File: rtl/gdsp_pkg.sv
// Shared receive-chain DSP definitions: sample format, 16-QAM levels, Gray codes
// and the slicer state encoding used by the TX mapper and RX slicer alike.
package gdsp_pkg;

  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int QAM_LVL_LO = 648;
  localparam int QAM_LVL_HI = 1943;
  localparam int QAM_THR    = 1296;

  // Adjacent levels differ in exactly one bit.
  localparam logic [1:0] GRAY_NEG_HI = 2'b00;
  localparam logic [1:0] GRAY_NEG_LO = 2'b01;
  localparam logic [1:0] GRAY_POS_LO = 2'b11;
  localparam logic [1:0] GRAY_POS_HI = 2'b10;

  typedef enum logic {
    ACQUIRE,
    LOCKED
  } slicer_state_t;

endpackage

// File: rtl/qam16_sym_slicer_rail.sv
// Single-rail 16-QAM hard decision: Gray bits plus the distance from the sample
// to the decided level, computed one bit wider than the sample so it never overflows.
module qam16_sym_slicer_rail
  import gdsp_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] x,
  output logic        [1:0]          bits,
  output logic        [SAMPLE_W:0]   err
);

  localparam logic signed [SAMPLE_W-1:0] THR_POS = SAMPLE_W'(QAM_THR);
  localparam logic signed [SAMPLE_W-1:0] THR_NEG = SAMPLE_W'(-QAM_THR);
  localparam logic signed [SAMPLE_W:0]   LVL_PH  = (SAMPLE_W+1)'(QAM_LVL_HI);
  localparam logic signed [SAMPLE_W:0]   LVL_PL  = (SAMPLE_W+1)'(QAM_LVL_LO);
  localparam logic signed [SAMPLE_W:0]   LVL_NL  = (SAMPLE_W+1)'(-QAM_LVL_LO);
  localparam logic signed [SAMPLE_W:0]   LVL_NH  = (SAMPLE_W+1)'(-QAM_LVL_HI);

  logic signed [SAMPLE_W:0] xw;
  logic signed [SAMPLE_W:0] lvl;
  logic signed [SAMPLE_W:0] diff;

  always_comb begin
    xw = {x[SAMPLE_W-1], x};
    if (x >= THR_POS) begin
      bits = GRAY_POS_HI;
      lvl  = LVL_PH;
    end else if (!x[SAMPLE_W-1]) begin
      bits = GRAY_POS_LO;
      lvl  = LVL_PL;
    end else if (x >= THR_NEG) begin
      bits = GRAY_NEG_LO;
      lvl  = LVL_NL;
    end else begin
      bits = GRAY_NEG_HI;
      lvl  = LVL_NH;
    end
    diff = xw - lvl;
    err  = diff[SAMPLE_W] ? -diff : diff;
  end

endmodule

// File: rtl/qam16_sym_slicer.sv
// 16-QAM symbol slicer: picks the sampling phase with the lowest accumulated slicer
// error, then decimates to one Gray symbol per SPS samples while watching window error.
module qam16_sym_slicer
  import gdsp_pkg::*;
#(
  parameter  int SPS      = 4,
  parameter  int ACQ_SYMS = 64,
  parameter  int ACC_W    = 20,
  parameter  int LOCK_THR = 24000,
  localparam int PH_W     = $clog2(SPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] din_I,
  input  logic signed [SAMPLE_W-1:0] din_Q,
  input  logic                       din_valid,
  input  logic                       reacq,
  output logic        [3:0]          sym_out,
  output logic                       sym_valid,
  output logic                       locked,
  output logic        [PH_W-1:0]     best_phase,
  output logic        [ACC_W-1:0]    err_metric,
  output logic                       lock_lost
);

  localparam int CNT_W = $clog2(ACQ_SYMS) + 1;
  localparam int ERR_W = SAMPLE_W + 2;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ERR_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  logic [1:0]          bits_i, bits_q;
  logic [SAMPLE_W:0]   err_i, err_q;
  logic [ERR_W-1:0]    err_s;

  slicer_state_t             state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [CNT_W-1:0]          sym_cnt_q, sym_cnt_d;
  logic [SPS-1:0][ACC_W-1:0] acc_q, acc_d, acc_add;
  logic [PH_W-1:0]           best_phase_q, best_phase_d, min_idx;
  logic [ACC_W-1:0]          err_metric_q, err_metric_d, min_val;
  logic                      locked_q, locked_d;
  logic                      lock_lost_q, lock_lost_d;
  logic                      sym_valid_q, sym_valid_d;
  logic [3:0]                sym_out_q, sym_out_d;
  logic                      sym_end, win_end;

  qam16_sym_slicer_rail u_rail_i (.x(din_I), .bits(bits_i), .err(err_i));
  qam16_sym_slicer_rail u_rail_q (.x(din_Q), .bits(bits_q), .err(err_q));

  assign err_s   = ERR_W'(err_i) + ERR_W'(err_q);
  assign sym_end = din_valid && (phase_q == PH_W'(SPS-1));
  assign win_end = sym_end && (sym_cnt_q == CNT_W'(ACQ_SYMS-1));

  // Accumulators as they stand after this sample; every phase while acquiring,
  // only the chosen phase once locked.
  always_comb begin
    acc_add = acc_q;
    if (din_valid && (state_q == ACQUIRE || phase_q == best_phase_q))
      acc_add[phase_q] = sat_add(acc_q[phase_q], err_s);
  end

  always_comb begin
    min_idx = '0;
    min_val = acc_add[0];
    for (int i = 1; i < SPS; i++) begin
      if (acc_add[i] < min_val) begin
        min_val = acc_add[i];
        min_idx = PH_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sym_cnt_d    = sym_cnt_q;
    acc_d        = acc_q;
    best_phase_d = best_phase_q;
    err_metric_d = err_metric_q;
    locked_d     = locked_q;
    lock_lost_d  = 1'b0;
    sym_valid_d  = 1'b0;
    sym_out_d    = sym_out_q;

    if (din_valid)
      phase_d = (phase_q == PH_W'(SPS-1)) ? '0 : phase_q + 1'b1;

    if (reacq) begin
      state_d   = ACQUIRE;
      locked_d  = 1'b0;
      acc_d     = '0;
      sym_cnt_d = '0;
    end else if (din_valid) begin
      acc_d = acc_add;
      if (sym_end)
        sym_cnt_d = win_end ? '0 : sym_cnt_q + 1'b1;

      if (state_q == ACQUIRE) begin
        if (win_end) begin
          best_phase_d = min_idx;
          err_metric_d = min_val;
          acc_d        = '0;
          state_d      = LOCKED;
          locked_d     = 1'b1;
        end
      end else begin
        if (phase_q == best_phase_q) begin
          sym_valid_d = 1'b1;
          sym_out_d   = {bits_i, bits_q};
        end
        if (win_end) begin
          err_metric_d = acc_add[best_phase_q];
          acc_d        = '0;
          if (acc_add[best_phase_q] > ACC_W'(LOCK_THR)) begin
            lock_lost_d = 1'b1;
            state_d     = ACQUIRE;
            locked_d    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACQUIRE;
      phase_q      <= '0;
      sym_cnt_q    <= '0;
      acc_q        <= '0;
      best_phase_q <= '0;
      err_metric_q <= '0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sym_cnt_q    <= sym_cnt_d;
      acc_q        <= acc_d;
      best_phase_q <= best_phase_d;
      err_metric_q <= err_metric_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
      sym_valid_q  <= sym_valid_d;
      sym_out_q    <= sym_out_d;
    end
  end

  assign sym_out    = sym_out_q;
  assign sym_valid  = sym_valid_q;
  assign locked     = locked_q;
  assign best_phase = best_phase_q;
  assign err_metric = err_metric_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_qam16_sym_slicer.sv
// Bench for qam16_sym_slicer: directed scenarios and a boundary table, with every
// cycle also scored against a per-sample integer model of the slicer.
module tb_qam16_sym_slicer;
  import gdsp_pkg::*;

  localparam int SPS      = 4;
  localparam int ACQ_SYMS = 64;
  localparam int ACC_W    = 20;
  localparam int LOCK_THR = 24000;
  localparam int PH_W     = 2;
  localparam int ACC_MAX  = (1 << ACC_W) - 1;
  localparam int IH       = 1943;
  localparam int IL       = 648;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic signed [SAMPLE_W-1:0] din_I = '0;
  logic signed [SAMPLE_W-1:0] din_Q = '0;
  logic                       din_valid = 1'b0;
  logic                       reacq = 1'b0;
  logic [3:0]                 sym_out;
  logic                       sym_valid;
  logic                       locked;
  logic [PH_W-1:0]            best_phase;
  logic [ACC_W-1:0]           err_metric;
  logic                       lock_lost;

  int n_chk = 0;
  int n_fail = 0;

  qam16_sym_slicer #(
    .SPS(SPS), .ACQ_SYMS(ACQ_SYMS), .ACC_W(ACC_W), .LOCK_THR(LOCK_THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din_I(din_I), .din_Q(din_Q), .din_valid(din_valid),
    .reacq(reacq), .sym_out(sym_out), .sym_valid(sym_valid), .locked(locked),
    .best_phase(best_phase), .err_metric(err_metric), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (per sample, plain integers) ----------------
  int         m_ph, m_nsym, m_best, m_err;
  int         m_acc [SPS];
  bit         m_locked, m_lost, m_sv;
  logic [3:0] m_sym;

  function automatic int ref_level(input int x);
    if (x >= QAM_THR) return QAM_LVL_HI;
    if (x >= 0)       return QAM_LVL_LO;
    if (x >= -QAM_THR) return -QAM_LVL_LO;
    return -QAM_LVL_HI;
  endfunction

  function automatic logic [1:0] ref_bits(input int x);
    case (ref_level(x))
      QAM_LVL_HI:  return 2'b10;
      QAM_LVL_LO:  return 2'b11;
      -QAM_LVL_LO: return 2'b01;
      default:     return 2'b00;
    endcase
  endfunction

  function automatic int ref_err(input int x);
    int d;
    d = x - ref_level(x);
    return (d < 0) ? -d : d;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_nsym = 0; m_best = 0; m_err = 0;
    m_locked = 0; m_lost = 0; m_sv = 0; m_sym = '0;
    for (int p = 0; p < SPS; p++) m_acc[p] = 0;
  endtask

  task automatic model_step(input bit v, input int i, input int q, input bit r);
    int e;
    m_lost = 0;
    m_sv   = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (r) begin
      m_locked = 0;
      m_nsym   = 0;
      for (int p = 0; p < SPS; p++) m_acc[p] = 0;
    end else if (v) begin
      e = ref_err(i) + ref_err(q);
      if (!m_locked || m_ph == m_best)
        m_acc[m_ph] = (m_acc[m_ph] + e > ACC_MAX) ? ACC_MAX : m_acc[m_ph] + e;
      if (m_locked && m_ph == m_best) begin
        m_sv  = 1;
        m_sym = {ref_bits(i), ref_bits(q)};
      end
      if (m_ph == SPS-1) begin
        m_nsym++;
        if (m_nsym == ACQ_SYMS) begin
          m_nsym = 0;
          if (!m_locked) begin
            m_best = 0;
            for (int p = 1; p < SPS; p++) if (m_acc[p] < m_acc[m_best]) m_best = p;
            m_err    = m_acc[m_best];
            m_locked = 1;
          end else begin
            m_err = m_acc[m_best];
            if (m_err > LOCK_THR) begin
              m_lost   = 1;
              m_locked = 0;
            end
          end
          for (int p = 0; p < SPS; p++) m_acc[p] = 0;
        end
      end
    end
    if (v) m_ph = (m_ph + 1) % SPS;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic score();
    chk("scoreboard",
        {7'd0, locked, lock_lost, sym_valid, best_phase, err_metric},
        {7'd0, m_locked, m_lost, m_sv, PH_W'(m_best), ACC_W'(m_err)});
    if (m_sv) chk("sb_sym", 32'(sym_out), 32'(m_sym));
  endtask

  task automatic step(input bit v, input int i, input int q, input bit r);
    din_valid = v;
    din_I     = SAMPLE_W'(i);
    din_Q     = SAMPLE_W'(q);
    reacq     = r;
    model_step(v, i, q, r);
    @(posedge clk);
    #1;
    score();
  endtask

  // One symbol: phase ph carries (i,q), the others (oi,oq); optional reacq on the last sample.
  task automatic send_pat(input int ph, input int i, input int q, input int oi, input int oq,
                          input bit r_last);
    for (int p = 0; p < SPS; p++)
      step(1'b1, (p == ph) ? i : oi, (p == ph) ? q : oq, r_last && (p == SPS-1));
  endtask

  task automatic sparse(input int i, input int q);
    step(1'b1, i, q, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
  endtask

  function automatic int rnd_level();
    case ($urandom_range(0, 3))
      0:       return -IH;
      1:       return -IL;
      2:       return IL;
      default: return IH;
    endcase
  endfunction

  typedef struct {
    int         x;
    logic [1:0] bits;
    int         err;
  } bnd_t;

  bnd_t bnd [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsv, nll, pb, ri, rq;
    bit rv, rr;

    bnd[0] = '{1296,  2'b10, 647};
    bnd[1] = '{1295,  2'b11, 647};
    bnd[2] = '{0,     2'b11, 648};
    bnd[3] = '{-1,    2'b01, 647};
    bnd[4] = '{-1296, 2'b01, 648};
    bnd[5] = '{-1297, 2'b00, 646};

    // Reset state
    model_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0);
    chk("reset_outputs", {3'd0, locked, lock_lost, sym_valid, best_phase, err_metric, sym_out}, 32'd0);
    rst_n = 1'b1;

    // Ideal input on phase 2: acquire, then one strobe per symbol
    for (int s = 0; s < ACQ_SYMS; s++) send_pat(2, IH, -IL, 0, 0, 1'b0);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_best", 32'(best_phase), 32'd2);
    chk("t1_err", 32'(err_metric), 32'd0);
    for (int s = 0; s < ACQ_SYMS; s++) begin
      for (int p = 0; p < SPS; p++) begin
        step(1'b1, (p == 2) ? IH : 0, (p == 2) ? -IL : 0, 1'b0);
        if (p == 2) chk("t1_sym", 32'({sym_valid, sym_out}), 32'h19);
        else        chk("t1_nostrobe", 32'(sym_valid), 32'd0);
      end
    end

    // Slicer boundaries at the locked phase: bits next cycle, error via one window
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < SPS; p++) begin
        step(1'b1, (p == 2) ? bnd[k].x : 0, (p == 2) ? -IL : 0, 1'b0);
        if (p == 2) chk("t2_bits", 32'({sym_valid, sym_out}), 32'({1'b1, bnd[k].bits, 2'b01}));
      end
      for (int s = 1; s < ACQ_SYMS; s++) send_pat(2, IH, -IL, 0, 0, 1'b0);
      chk("t2_err", 32'(err_metric), 32'(bnd[k].err));
      chk("t2_locked", 32'(locked), 32'd1);
    end

    // reacq on the window-end sample of a failing window
    for (int s = 0; s < ACQ_SYMS-1; s++) send_pat(2, IH+200, -IL-200, 0, 0, 1'b0);
    send_pat(2, IH+200, -IL-200, 0, 0, 1'b1);
    chk("t5_no_lost", 32'(lock_lost), 32'd0);
    chk("t5_unlocked", 32'(locked), 32'd0);
    nsv = 0; nll = 0;
    for (int s = 0; s < ACQ_SYMS; s++) begin
      for (int p = 0; p < SPS; p++) begin
        step(1'b1, (p == 2) ? IH : 0, (p == 2) ? -IL : 0, 1'b0);
        if (sym_valid) nsv++;
        if (lock_lost) nll++;
      end
    end
    chk("t5_no_sym", 32'(nsv), 32'd0);
    chk("t5_no_lost_acq", 32'(nll), 32'd0);
    chk("t5_relock", 32'(locked), 32'd1);

    // Offset samples on the locked phase: 400 per symbol, lock drops at window end
    nll = 0;
    for (int s = 0; s < ACQ_SYMS; s++) begin
      for (int p = 0; p < SPS; p++) begin
        step(1'b1, (p == 2) ? IH+200 : 0, (p == 2) ? -IL-200 : 0, 1'b0);
        if (lock_lost) nll++;
      end
    end
    chk("t4_pulse_at_end", 32'(lock_lost), 32'd1);
    chk("t4_pulse_count", 32'(nll), 32'd1);
    chk("t4_unlocked", 32'(locked), 32'd0);
    chk("t4_err", 32'(err_metric), 32'd25600);
    step(1'b0, 0, 0, 1'b0);
    chk("t4_pulse_width", 32'(lock_lost), 32'd0);
    for (int s = 0; s < ACQ_SYMS; s++) send_pat(1, IH, -IL, 0, 0, 1'b0);
    chk("t4_relock_best", 32'({locked, best_phase}), 32'({1'b1, 2'd1}));
    chk("t4_relock_err", 32'(err_metric), 32'd0);

    // Tie between two ideal phases goes to the lower index
    step(1'b0, 0, 0, 1'b1);
    for (int s = 0; s < ACQ_SYMS; s++) begin
      for (int p = 0; p < SPS; p++) begin
        if (p % 2 == 1) step(1'b1, IH, -IL, 1'b0);
        else step(1'b1, int'($urandom_range(0, 3000)) - 1500, int'($urandom_range(0, 3000)) - 1500, 1'b0);
      end
    end
    chk("t3_tie_best", 32'({locked, best_phase}), 32'({1'b1, 2'd1}));

    // Full-scale samples on every phase: all accumulators saturate
    step(1'b0, 0, 0, 1'b1);
    for (int s = 0; s < ACQ_SYMS; s++) send_pat(0, -32768, 32767, -32768, 32767, 1'b0);
    chk("sat_best", 32'({locked, best_phase}), 32'({1'b1, 2'd0}));
    chk("sat_err", 32'(err_metric), 32'(ACC_MAX));

    // Randomized traffic with gaps, phase changes and occasional reacq
    step(1'b0, 0, 0, 1'b1);
    pb = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 0) pb = $urandom_range(0, SPS-1);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 499) == 0);
      if (m_ph == pb) begin
        ri = rnd_level() + int'($urandom_range(0, 120)) - 60;
        rq = rnd_level() + int'($urandom_range(0, 120)) - 60;
      end else begin
        ri = int'($urandom_range(0, 6000)) - 3000;
        rq = int'($urandom_range(0, 6000)) - 3000;
      end
      step(rv, ri, rq, rr);
    end

    // Sparse input (every third cycle) then asynchronous reset mid-acquisition
    step(1'b0, 0, 0, 1'b1);
    for (int s = 0; s < ACQ_SYMS; s++)
      for (int p = 0; p < SPS; p++) sparse((p == 2) ? IH : 0, (p == 2) ? -IL : 0);
    chk("t6_sparse_best", 32'({locked, best_phase}), 32'({1'b1, 2'd2}));
    chk("t6_sparse_err", 32'(err_metric), 32'd0);
    step(1'b0, 0, 0, 1'b1);
    for (int s = 0; s < 20; s++)
      for (int p = 0; p < SPS; p++) sparse((p == 1) ? IH : 0, (p == 1) ? -IL : 0);
    sparse(0, 0);
    sparse(IH, -IL);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_reset", {3'd0, locked, lock_lost, sym_valid, best_phase, err_metric, sym_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < ACQ_SYMS; s++)
      for (int p = 0; p < SPS; p++) sparse((p == 1) ? IH : 0, (p == 1) ? -IL : 0);
    chk("t6_restart_best", 32'({locked, best_phase}), 32'({1'b1, 2'd1}));
    chk("t6_restart_err", 32'(err_metric), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
